// File: rtl/tape_pkg.sv
// Shared constants for the cassette recorder: FSM state codes, default
// cycle thresholds and the period counter geometry.
package tape_pkg;
  localparam int PER_W      = 8;
  localparam logic [PER_W-1:0] PER_SAT = 8'hFF;
  localparam logic [PER_W-1:0] PER_PRE = 8'hFE;

  localparam int SHORT_MAX_D = 17;
  localparam int LONG_MAX_D  = 35;
  localparam int LEAD_MIN_D  = 8;

  typedef logic [2:0] state_t;
  localparam state_t ST_OFF  = 3'd0;
  localparam state_t ST_HUNT = 3'd1;
  localparam state_t ST_SYNC = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_STOP = 3'd4;
endpackage

// File: rtl/tape_period.sv
// Rising-edge detector on cass_out, saturating period counter in ce_smp
// ticks, and short/long/gap classification of each completed cycle.
module tape_period
  import tape_pkg::*;
#(
  parameter int SHORT_MAX = SHORT_MAX_D,
  parameter int LONG_MAX  = LONG_MAX_D
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce_smp,
  input  logic cass_out,
  output logic bit_vld,
  output logic bit_val,
  output logic gap,
  output logic timeout
);
  localparam logic [PER_W-1:0] SHORT_LIM = PER_W'(SHORT_MAX);
  localparam logic [PER_W-1:0] LONG_LIM  = PER_W'(LONG_MAX);

  logic             r_cur, r_prev;
  logic [PER_W-1:0] r_cnt;
  logic             w_rise;

  assign w_rise = r_cur & ~r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_cur  <= cass_out;
      r_prev <= r_cur;
      // a tick landing on the edge clock belongs to the new period
      if (w_rise)
        r_cnt <= {{(PER_W-1){1'b0}}, ce_smp};
      else if (ce_smp && r_cnt != PER_SAT)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bit_vld = w_rise && (r_cnt != '0) && (r_cnt <= LONG_LIM);
  assign bit_val = (r_cnt <= SHORT_LIM);
  assign gap     = w_rise && (r_cnt > LONG_LIM);
  assign timeout = ce_smp && !w_rise && (r_cnt == PER_PRE);
endmodule

// File: rtl/tape_rec.sv
// Cassette recorder: frames decoded bits into bytes (leader, start, 8 data
// LSB first, 2 stops) and writes them sequentially into the tape RAM.
module tape_rec
  import tape_pkg::*;
#(
  parameter int SHORT_MAX = SHORT_MAX_D,
  parameter int LONG_MAX  = LONG_MAX_D,
  parameter int LEAD_MIN  = LEAD_MIN_D,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_smp,
  input  logic              enable,
  input  logic              cass_out,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic [ADDR_W-1:0] length,
  output logic              recording,
  output logic              done,
  output logic              frame_err,
  output logic              full
);
  localparam int LW = $clog2(LEAD_MIN + 1);
  localparam logic [LW-1:0] LEAD_LAST = LW'(LEAD_MIN - 1);

  logic w_bit_vld, w_bit_val, w_gap, w_timeout;
  logic [7:0] w_byte;

  tape_period #(.SHORT_MAX(SHORT_MAX), .LONG_MAX(LONG_MAX)) u_period (
    .clk(clk), .reset_n(reset_n), .ce_smp(ce_smp), .cass_out(cass_out),
    .bit_vld(w_bit_vld), .bit_val(w_bit_val), .gap(w_gap), .timeout(w_timeout)
  );

  state_t            r_state;
  logic [LW-1:0]     r_lead;
  logic [2:0]        r_idx;
  logic [7:0]        r_shift;
  logic              r_stop, r_en_q;
  logic              r_wr, r_rec, r_done, r_ferr, r_full;
  logic [ADDR_W-1:0] r_addr, r_length;
  logic [7:0]        r_data;

  assign w_byte = {w_bit_val, r_shift[7:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_OFF;  r_lead <= '0;  r_idx <= '0;  r_shift <= '0;
      r_stop <= 1'b0;     r_en_q <= 1'b0; r_wr <= 1'b0; r_rec <= 1'b0;
      r_done <= 1'b0;     r_ferr <= 1'b0; r_full <= 1'b0;
      r_addr <= '0;       r_length <= '0; r_data <= '0;
    end else begin
      r_en_q <= enable;
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      if (!enable) begin
        r_state <= ST_OFF;
        if (r_rec) begin
          r_rec  <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (!r_en_q) begin
        r_state  <= ST_HUNT;
        r_length <= '0;
        r_full   <= 1'b0;
        r_lead   <= '0;
      end else if (w_timeout && r_rec) begin
        r_rec   <= 1'b0;
        r_done  <= 1'b1;
        r_state <= ST_HUNT;
        r_lead  <= '0;
      end else if (w_gap) begin
        r_state <= ST_HUNT;
        r_lead  <= '0;
      end else if (w_bit_vld) begin
        case (r_state)
          ST_HUNT:
            if (!w_bit_val) r_lead <= '0;
            else if (r_lead == LEAD_LAST) begin
              r_lead  <= '0;
              r_state <= ST_SYNC;
            end else r_lead <= r_lead + 1'b1;
          ST_SYNC:
            if (!w_bit_val) begin
              r_state <= ST_DATA;
              r_idx   <= '0;
            end
          ST_DATA: begin
            r_shift <= w_byte;
            if (r_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_stop  <= 1'b0;
              // last address is never written; it marks the buffer full
              if (&r_length) r_full <= 1'b1;
              else begin
                r_wr     <= 1'b1;
                r_addr   <= r_length;
                r_data   <= w_byte;
                r_length <= r_length + 1'b1;
                r_rec    <= 1'b1;
              end
            end else r_idx <= r_idx + 1'b1;
          end
          ST_STOP:
            if (!w_bit_val) begin
              r_ferr  <= 1'b1;
              r_state <= ST_SYNC;
            end else if (r_stop) r_state <= ST_SYNC;
            else r_stop <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign wr        = r_wr;
  assign addr      = r_addr;
  assign data      = r_data;
  assign length    = r_length;
  assign recording = r_rec;
  assign done      = r_done;
  assign frame_err = r_ferr;
  assign full      = r_full;
endmodule

// File: doc/tape_rec.md
# tape_rec

Cassette recorder: the write-side counterpart of the tape playback block. Monitors the Aquarius `cass_out` square wave, measures cycle periods, decodes bits and bytes, and writes the bytes sequentially into the tape RAM so the host can save them as a CAQ image. Sits beside the playback block on `clk_sys`, sharing the tape RAM write port with the ioctl loader; the top level muxes that port with `recording`.

## Interface
Parameters:
- `SHORT_MAX`, 17: max period (ce_smp ticks) classified as a short cycle = bit 1
- `LONG_MAX`, 35: max period classified as a long cycle = bit 0; longer = gap
- `LEAD_MIN`, 8: consecutive 1-bits required as leader before byte sync
- `ADDR_W`, 16: tape RAM address width

Ports:
- `clk` in 1: system clock (clk_sys)
- `reset_n` in 1: asynchronous, active-low reset
- `ce_smp` in 1: sample tick, nominal 28 kHz, one clk wide
- `enable` in 1: arm recording; rising edge clears `length`
- `cass_out` in 1: cassette output level from the PLA (clk domain)
- `wr` out 1: one-clk RAM write strobe
- `addr` out ADDR_W: write address
- `data` out 8: write data
- `length` out ADDR_W: bytes captured so far
- `recording` out 1: at least one byte captured, session not yet ended
- `done` out 1: one-clk pulse when a session ends
- `frame_err` out 1: one-clk pulse on bad stop bit
- `full` out 1: sticky, length reached 2^ADDR_W-1; later bytes dropped

## Operation
- Edge detect: `cass_out` registered every clk; rising edge = prev 0, cur 1.
- Period counter: 8-bit, increments on `ce_smp`, saturates at 255. On rising edge: captured period = cnt, cnt <= (ce_smp ? 1 : 0).
- Classify on rising edge: period 0 ignored (glitch); 1..SHORT_MAX → bit 1; SHORT_MAX+1..LONG_MAX → bit 0; >LONG_MAX → gap.
- FSM states: OFF, HUNT, SYNC, DATA, STOP.
  - OFF: `enable`=0. `enable` rising → HUNT, length=0, full=0.
  - HUNT: count consecutive 1-bits; 0-bit or gap clears count; count = LEAD_MIN → SYNC.
  - SYNC: 1-bits stay; 0-bit (start) → DATA, bit index 0; gap → HUNT.
  - DATA: shift in 8 bits LSB first; after 8th → write byte, → STOP, stop index 0; gap → HUNT, partial byte discarded.
  - STOP: two 1-bits → SYNC. A 0-bit → frame_err pulse, → SYNC (that bit consumed). Gap → HUNT.
- Write: `addr` = length, `data` = assembled byte, `wr` pulse, length++. If length = 2^ADDR_W-1: no write, `full` set.
- `recording` rises with first write; session ends when cnt saturates at 255 while recording, or `enable` falls while recording → `done` pulse, `recording` 0, state HUNT (or OFF if disabled). `length` retained until next `enable` rise.
- `enable` low in any state → OFF immediately; in-flight byte discarded.

## Timing
- Reset values: all outputs 0; state OFF; counters 0.
- Latency: rising edge completing the 8th data bit → `wr` high the next clk, for exactly one clk; `length` updates in the same clk as `wr`.
- `done` and `frame_err` never coincide with `wr`.
- Edge and `ce_smp` in same clk: edge wins for capture; counter restarts at 1.
- Thresholds are absolute ticks; top level scales `ce_smp` with CPU speed.
- Async reset mid-byte: everything cleared, no `done`.

## Structure
- `tape_pkg`: FSM state enum, default SHORT_MAX/LONG_MAX/LEAD_MIN, period width (8) and saturation value.
- Sub-module `tape_period`: edge detector, saturating period counter, classifier; outputs one-clk `bit_vld`, `bit_val`, `gap`, `timeout`. `tape_rec` holds the FSM, shifter and write logic.

## Test plan
- 16 short cycles (12 ticks), start, byte 0xA5 (long/short per bit), two stops → one `wr`, addr 0, data 0xA5, length 1, recording 1.
- Three bytes 0x00, 0xFF, 0x3C back to back, then 300 ticks silence → writes at addr 0,1,2; `done` one clk after cnt hits 255; length 3.
- Stop bit sent as long cycle → `frame_err` pulse, no extra write; next framed byte 0x11 written at next addr.
- Only 7 leader bits then start+byte → no write; with 8 leader bits → write occurs.
- Gap (50 ticks) after 4 data bits → no write, state HUNT; `enable` dropped mid-byte → no write, `done` only if length>0.
- ADDR_W=4: 16 bytes → 15 writes, `full` 1; toggle `enable` → length 0, full 0; `reset_n` low mid-byte → all outputs 0.
